cpu_decode_queue: RTL

//  Parametrised decode stage placed between CPU_Fetch and CPU_Execute.
//  - Decodes each fetch_data_t into a decode_data_t using the generated instruction tables.
//  - Holds results in a DEPTH-entry output queue with valid/ready handshakes on both sides.
//  - Adds pipeline flush and an illegal-instruction fault FSM: halt, drain, then wait for flush.

---
 rtl/cpu_decode_queue_pkg.sv | 103 ++++++++++
 rtl/cpu_decode_queue_logic.sv | 51 +++++
 rtl/cpu_decode_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_decode_queue_pkg.sv
// Shared types for the decode stage: fetch/decode payloads, FSM states and the
// instruction match table consumed by the combinational decoder.
package cpu_decode_queue_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned OP_W  = 5;

  typedef logic [OP_W-1:0] decode_op_t;

  localparam decode_op_t DECODE_OP_ILLEGAL = 5'd0;
  localparam decode_op_t OP_ADDI  = 5'd1;
  localparam decode_op_t OP_ADD   = 5'd2;
  localparam decode_op_t OP_SUB   = 5'd3;
  localparam decode_op_t OP_ANDI  = 5'd4;
  localparam decode_op_t OP_ORI   = 5'd5;
  localparam decode_op_t OP_XORI  = 5'd6;
  localparam decode_op_t OP_SLLI  = 5'd7;
  localparam decode_op_t OP_LW    = 5'd8;
  localparam decode_op_t OP_SW    = 5'd9;
  localparam decode_op_t OP_BEQ   = 5'd10;
  localparam decode_op_t OP_JAL   = 5'd11;
  localparam decode_op_t OP_LUI   = 5'd12;
  localparam decode_op_t OP_FMADD = 5'd13;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} decode_state_t;

  typedef enum logic [1:0] {SRC_ZERO, SRC_RS, SRC_IMM, SRC_PC} alu_src_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_FMA} alu_op_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instruction;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs3;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } fetch_data_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] inst_rs1;
    logic [REG_W-1:0] inst_rs2;
    logic [REG_W-1:0] inst_rs3;
    logic [REG_W-1:0] inst_rd;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic [2:0]       have_rs;
    logic             arithmetic;
    logic             logical;
    logic             shift;
    logic             branch;
    logic             jump;
    logic             load;
    logic             store;
    alu_op_t          alu_operation;
    alu_src_t         alu_operand1;
    alu_src_t         alu_operand2;
    logic             memory_read;
    logic             memory_write;
    logic [1:0]       memory_size;
    logic             memory_signed;
    decode_op_t       op;
  } decode_data_t;

  // cls = {arithmetic, logical, shift, branch, jump, load, store}
  typedef struct packed {
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] match;
    decode_op_t      op;
    logic [6:0]      cls;
    alu_op_t         alu;
    alu_src_t        src1;
    alu_src_t        src2;
    logic            mem_rd;
    logic            mem_wr;
    logic [1:0]      mem_size;
    logic            mem_signed;
  } inst_entry_t;

  localparam int unsigned INST_COUNT = 13;

  localparam inst_entry_t INST_TABLE [INST_COUNT] = '{
    '{32'h0000707F, 32'h00000013, OP_ADDI,  7'b1000000, ALU_ADD, SRC_RS,   SRC_IMM, 1'b0, 1'b0, 2'd0, 1'b0},
    '{32'hFE00707F, 32'h00000033, OP_ADD,   7'b1000000, ALU_ADD, SRC_RS,   SRC_RS,  1'b0, 1'b0, 2'd0, 1'b0},
    '{32'hFE00707F, 32'h40000033, OP_SUB,   7'b1000000, ALU_SUB, SRC_RS,   SRC_RS,  1'b0, 1'b0, 2'd0, 1'b0},
    '{32'h0000707F, 32'h00007013, OP_ANDI,  7'b0100000, ALU_AND, SRC_RS,   SRC_IMM, 1'b0, 1'b0, 2'd0, 1'b0},
    '{32'h0000707F, 32'h00006013, OP_ORI,   7'b0100000, ALU_OR,  SRC_RS,   SRC_IMM, 1'b0, 1'b0, 2'd0, 1'b0},
    '{32'h0000707F, 32'h00004013, OP_XORI,  7'b0100000, ALU_XOR, SRC_RS,   SRC_IMM, 1'b0, 1'b0, 2'd0, 1'b0},
    '{32'hFE00707F, 32'h00001013, OP_SLLI,  7'b0010000, ALU_SLL, SRC_RS,   SRC_IMM, 1'b0, 1'b0, 2'd0, 1'b0},
    '{32'h0000707F, 32'h00002003, OP_LW,    7'b0000010, ALU_ADD, SRC_RS,   SRC_IMM, 1'b1, 1'b0, 2'd2, 1'b1},
    '{32'h0000707F, 32'h00002023, OP_SW,    7'b0000001, ALU_ADD, SRC_RS,   SRC_IMM, 1'b0, 1'b1, 2'd2, 1'b0},
    '{32'h0000707F, 32'h00000063, OP_BEQ,   7'b0001000, ALU_SUB, SRC_RS,   SRC_RS,  1'b0, 1'b0, 2'd0, 1'b0},
    '{32'h0000007F, 32'h0000006F, OP_JAL,   7'b0000100, ALU_ADD, SRC_PC,   SRC_IMM, 1'b0, 1'b0, 2'd0, 1'b0},
    '{32'h0000007F, 32'h00000037, OP_LUI,   7'b1000000, ALU_ADD, SRC_ZERO, SRC_IMM, 1'b0, 1'b0, 2'd0, 1'b0},
    '{32'h0600007F, 32'h00000043, OP_FMADD, 7'b1000000, ALU_FMA, SRC_RS,   SRC_RS,  1'b0, 1'b0, 2'd0, 1'b0}
  };

endpackage

// File: rtl/cpu_decode_queue_logic.sv
// Combinational decoder: first matching table entry supplies class/ALU/memory
// fields; no match yields op=0 with all class flags clear and illegal_c set.
module cpu_decode_queue_logic
  import cpu_decode_queue_pkg::*;
#(
  parameter bit ENABLE_RS3 = 1'b1
) (
  input  fetch_data_t  fetch,
  output decode_data_t decode_c,
  output logic         illegal_c
);

  inst_entry_t entry;
  logic        hit;

  always_comb begin
    hit   = 1'b0;
    entry = '0;
    for (int unsigned i = 0; i < INST_COUNT; i++) begin
      if (!hit && ((fetch.instruction & INST_TABLE[i].mask) == INST_TABLE[i].match)) begin
        hit   = 1'b1;
        entry = INST_TABLE[i];
      end
    end
  end

  always_comb begin
    decode_c          = '0;
    decode_c.pc       = fetch.pc;
    decode_c.inst_rs1 = fetch.rs1;
    decode_c.inst_rs2 = fetch.rs2;
    decode_c.inst_rs3 = ENABLE_RS3 ? fetch.rs3 : '0;
    decode_c.inst_rd  = fetch.rd;
    decode_c.imm      = fetch.imm;
    decode_c.tag      = fetch.tag;
    decode_c.have_rs  = {ENABLE_RS3 && (fetch.rs3 != '0), fetch.rs2 != '0, fetch.rs1 != '0};
    {decode_c.arithmetic, decode_c.logical, decode_c.shift, decode_c.branch,
     decode_c.jump, decode_c.load, decode_c.store} = entry.cls;
    decode_c.alu_operation = entry.alu;
    decode_c.alu_operand1  = entry.src1;
    decode_c.alu_operand2  = entry.src2;
    decode_c.memory_read   = entry.mem_rd;
    decode_c.memory_write  = entry.mem_wr;
    decode_c.memory_size   = entry.mem_size;
    decode_c.memory_signed = entry.mem_signed;
    decode_c.op            = entry.op;
  end

  assign illegal_c = !hit;

endmodule

// File: rtl/cpu_decode_queue.sv
// Decode stage between fetch and execute: decodes into a DEPTH-entry queue with
// valid/ready on both sides, flush, and a halt-drain-wait fault FSM.
module cpu_decode_queue
  import cpu_decode_queue_pkg::*;
#(
  parameter  int unsigned DEPTH      = 2,
  parameter  bit          ENABLE_RS3 = 1'b1,
  localparam int unsigned COUNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_flush,
  input  fetch_data_t        i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output decode_data_t       o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_fault,
  output logic [XLEN-1:0]    o_fault_pc,
  output logic [COUNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [COUNT_W-1:0] count_t;

  decode_data_t    mem [DEPTH];
  ptr_t            wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  count_t          count_d;
  decode_state_t   state, state_d;
  decode_data_t    dec_c, head_d;
  logic            illegal_c;
  logic            enq, deq;
  logic            ready_d, valid_d, fault_d;
  logic [XLEN-1:0] fault_pc_d;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  cpu_decode_queue_logic #(
    .ENABLE_RS3(ENABLE_RS3)
  ) u_logic (
    .fetch    (i_data),
    .decode_c (dec_c),
    .illegal_c(illegal_c)
  );

  // Flush overrides both handshakes in the same cycle.
  assign enq = i_valid && o_ready && !i_flush;
  assign deq = o_valid && i_ready && !i_flush;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= RUN;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (i_flush) begin
      state_d = RUN;
    end else begin
      case (state)
        RUN:     if (enq && illegal_c) state_d = DRAIN;
        DRAIN:   if (count_d == '0) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = o_count;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = ptr_inc(wr_ptr);
      if (deq) rd_ptr_d = ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count_d = o_count + count_t'(1);
        2'b01:   count_d = o_count - count_t'(1);
        default: count_d = o_count;
      endcase
    end
  end

  // Next-cycle values of the registered outputs; a write landing on the new
  // head slot bypasses the storage array.
  always_comb begin
    ready_d    = (state_d == RUN) && (count_d < count_t'(DEPTH));
    valid_d    = (count_d != '0);
    head_d     = (enq && (wr_ptr == rd_ptr_d)) ? dec_c : mem[rd_ptr_d];
    fault_d    = o_fault;
    fault_pc_d = o_fault_pc;
    if (i_flush) begin
      fault_d = 1'b0;
    end else if (enq && illegal_c) begin
      fault_d    = 1'b1;
      fault_pc_d = i_data.pc;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_ready    <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_fault    <= 1'b0;
      o_fault_pc <= '0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      o_count    <= count_d;
      o_ready    <= ready_d;
      o_valid    <= valid_d;
      o_data     <= head_d;
      o_fault    <= fault_d;
      o_fault_pc <= fault_pc_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (enq) mem[wr_ptr] <= dec_c;
  end

endmodule
